// File: rtl/ex_mem_latch_if.sv
// EX -> MEM boundary bundle for the EX/MEM pipeline register.
// The i_* group is what the EX stage presents and the o_* group is what
// the MEM stage sees one cycle later.
interface ex_mem_latch_if #(
   parameter int DATA_SIZE     = 32,
   parameter int REG_ADDR_SIZE = 5,
   parameter int PC_SIZE       = 32
);
   logic                     i_enable;
   logic                     i_stall;
   logic                     i_flush;
   logic                     i_valid;
   logic [DATA_SIZE-1:0]     i_alu_result;
   logic                     i_zero;
   logic [DATA_SIZE-1:0]     i_rt_data;
   logic [REG_ADDR_SIZE-1:0] i_write_reg;
   logic [PC_SIZE-1:0]       i_pc_plus4;
   logic                     i_reg_write;
   logic                     i_mem_to_reg;
   logic                     i_mem_read;
   logic                     i_mem_write;
   logic                     i_link;
   logic [1:0]               i_bhw_type;
   logic                     i_load_unsigned;
   logic                     i_halt;

   logic                     o_valid;
   logic [DATA_SIZE-1:0]     o_alu_result;
   logic                     o_zero;
   logic [DATA_SIZE-1:0]     o_rt_data;
   logic [REG_ADDR_SIZE-1:0] o_write_reg;
   logic [PC_SIZE-1:0]       o_pc_plus4;
   logic                     o_reg_write;
   logic                     o_mem_to_reg;
   logic                     o_mem_read;
   logic                     o_mem_write;
   logic                     o_link;
   logic [1:0]               o_bhw_type;
   logic                     o_load_unsigned;
   logic                     o_halt;
   logic [31:0]              o_ex_count;

   // EX-side driver: presents the instruction and sees the latched copy
   modport master (
      output i_enable, i_stall, i_flush, i_valid, i_alu_result, i_zero,
             i_rt_data, i_write_reg, i_pc_plus4, i_reg_write, i_mem_to_reg,
             i_mem_read, i_mem_write, i_link, i_bhw_type, i_load_unsigned,
             i_halt,
      input  o_valid, o_alu_result, o_zero, o_rt_data, o_write_reg,
             o_pc_plus4, o_reg_write, o_mem_to_reg, o_mem_read, o_mem_write,
             o_link, o_bhw_type, o_load_unsigned, o_halt, o_ex_count
   );

   // The pipeline register itself
   modport slave (
      input  i_enable, i_stall, i_flush, i_valid, i_alu_result, i_zero,
             i_rt_data, i_write_reg, i_pc_plus4, i_reg_write, i_mem_to_reg,
             i_mem_read, i_mem_write, i_link, i_bhw_type, i_load_unsigned,
             i_halt,
      output o_valid, o_alu_result, o_zero, o_rt_data, o_write_reg,
             o_pc_plus4, o_reg_write, o_mem_to_reg, o_mem_read, o_mem_write,
             o_link, o_bhw_type, o_load_unsigned, o_halt, o_ex_count
   );
endinterface

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register of the five-stage MIPS core.
// Captures the EX result and MEM/WB control bits, supports hold, bubble
// insertion, a sticky halt that freezes everything after HALT has passed,
// and counts the real instructions that leave EX.
module ex_mem_latch #(
   parameter int DATA_SIZE     = 32,
   parameter int REG_ADDR_SIZE = 5,
   parameter int PC_SIZE       = 32
) (
   input  logic          i_clk,
   input  logic          i_reset,
   ex_mem_latch_if.slave bus
);

   // RUN while instructions flow; HALTED once the HALT instruction is latched
   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   state_t                   r_state;
   logic                     r_valid;
   logic [DATA_SIZE-1:0]     r_aluResult;
   logic                     r_zero;
   logic [DATA_SIZE-1:0]     r_rtData;
   logic [REG_ADDR_SIZE-1:0] r_writeReg;
   logic [PC_SIZE-1:0]       r_pcPlus4;
   logic                     r_regWrite;
   logic                     r_memToReg;
   logic                     r_memRead;
   logic                     r_memWrite;
   logic                     r_link;
   logic [1:0]               r_bhwType;
   logic                     r_loadUnsigned;
   logic [31:0]              r_exCount;

   logic                     w_load;
   logic                     w_haltIn;

   // A load happens only when the stage is enabled and not stalled; flush
   // is checked ahead of this so it beats both hold sources
   assign w_load   = bus.i_enable & ~bus.i_stall;
   // HALT only counts when it rides on a real instruction
   assign w_haltIn = bus.i_halt & bus.i_valid;

   // Pipeline register, halt state machine and instruction counter.
   // Order of precedence: reset, halted freeze, flush (bubble), hold, load.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state        <= ST_RUN;
         r_valid        <= 1'b0;
         r_aluResult    <= '0;
         r_zero         <= 1'b0;
         r_rtData       <= '0;
         r_writeReg     <= '0;
         r_pcPlus4      <= '0;
         r_regWrite     <= 1'b0;
         r_memToReg     <= 1'b0;
         r_memRead      <= 1'b0;
         r_memWrite     <= 1'b0;
         r_link         <= 1'b0;
         r_bhwType      <= 2'b00;
         r_loadUnsigned <= 1'b0;
         r_exCount      <= '0;
      end else if (r_state == ST_RUN) begin
         if (bus.i_flush) begin
            r_state        <= ST_RUN;
            r_valid        <= 1'b0;
            r_aluResult    <= '0;
            r_zero         <= 1'b0;
            r_rtData       <= '0;
            r_writeReg     <= '0;
            r_pcPlus4      <= '0;
            r_regWrite     <= 1'b0;
            r_memToReg     <= 1'b0;
            r_memRead      <= 1'b0;
            r_memWrite     <= 1'b0;
            r_link         <= 1'b0;
            r_bhwType      <= 2'b00;
            r_loadUnsigned <= 1'b0;
         end else if (w_load) begin
            r_state        <= w_haltIn ? ST_HALTED : ST_RUN;
            r_valid        <= bus.i_valid;
            r_aluResult    <= bus.i_alu_result;
            r_zero         <= bus.i_zero;
            r_rtData       <= bus.i_rt_data;
            r_writeReg     <= bus.i_write_reg;
            r_pcPlus4      <= bus.i_pc_plus4;
            r_regWrite     <= bus.i_reg_write  & bus.i_valid;
            r_memToReg     <= bus.i_mem_to_reg & bus.i_valid;
            r_memRead      <= bus.i_mem_read   & bus.i_valid;
            r_memWrite     <= bus.i_mem_write  & bus.i_valid;
            r_link         <= bus.i_link       & bus.i_valid;
            r_bhwType      <= bus.i_bhw_type;
            r_loadUnsigned <= bus.i_load_unsigned;
            if (bus.i_valid) begin
               r_exCount <= r_exCount + 32'd1;
            end
         end
      end
   end

   assign bus.o_valid         = r_valid;
   assign bus.o_alu_result    = r_aluResult;
   assign bus.o_zero          = r_zero;
   assign bus.o_rt_data       = r_rtData;
   assign bus.o_write_reg     = r_writeReg;
   assign bus.o_pc_plus4      = r_pcPlus4;
   assign bus.o_reg_write     = r_regWrite;
   assign bus.o_mem_to_reg    = r_memToReg;
   assign bus.o_mem_read      = r_memRead;
   assign bus.o_mem_write     = r_memWrite;
   assign bus.o_link          = r_link;
   assign bus.o_bhw_type      = r_bhwType;
   assign bus.o_load_unsigned = r_loadUnsigned;
   assign bus.o_halt          = (r_state == ST_HALTED);
   assign bus.o_ex_count      = r_exCount;

endmodule
